// File: rtl/turbo_pkg.sv
// Shared trellis definitions for the turbo chain: memory length, state vector and one RSC step.
package turbo_pkg;

    localparam int MAX_M    = 8;
    localparam int MAX_NOUT = 8;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_TAIL = 1'b1
    } enc_fsm_e;

    // Bit k-1 holds delay element dk.
    typedef logic [MAX_M-1:0]              rsc_state_t;
    // Per output j, bit k is the tap on dk (d0 = feedback bit a).
    typedef logic [MAX_NOUT-1:0][MAX_M:0]  rsc_polys_t;

    typedef struct packed {
        rsc_state_t            next;
        logic [MAX_NOUT-1:0]   sym;
        logic                  fb;
    } rsc_step_t;

    function automatic int mem_len(input int states);
        return (states <= 2) ? 1 : $clog2(states);
    endfunction

    // XOR of the recursive taps over d1..dM; feeding this back as u forces a = 0.
    function automatic logic rsc_feedback(input rsc_state_t d, input rsc_state_t rtaps);
        return ^(d & rtaps);
    endfunction

    function automatic rsc_step_t rsc_step(input rsc_state_t d,
                                           input logic       u,
                                           input rsc_state_t rtaps,
                                           input rsc_polys_t ptaps);
        rsc_step_t        r;
        logic             a;
        logic [MAX_M:0]   w;
        r = '0;
        a = u ^ rsc_feedback(d, rtaps);
        w = {d, a};
        for (int j = 0; j < MAX_NOUT; j++) begin
            r.sym[j] = ^(ptaps[j] & w);
        end
        r.next = w[MAX_M-1:0];
        r.fb   = a;
        return r;
    endfunction

endpackage

// File: rtl/rsc_encoder_step_logic.sv
// Combinational trellis step around turbo_pkg::rsc_step; selects the terminating input during tail.
module rsc_step_logic
    import turbo_pkg::*;
#(
    parameter int STATES    = 4,
    parameter int NOUT      = 2,
    parameter int RECURSIVE = 7,
    parameter int POLY [NOUT] = '{5, 7},
    localparam int M        = mem_len(STATES)
) (
    input  logic [M-1:0]    state,
    input  logic            tail,
    input  logic            u,
    output logic [M-1:0]    state_nx,
    output logic [NOUT-1:0] symbol,
    output logic            u_eff
);

    if (M > MAX_M || NOUT > MAX_NOUT) begin : g_size_check
        $error("rsc_step_logic: STATES/NOUT exceed turbo_pkg limits");
    end

    rsc_state_t rtaps;
    rsc_polys_t ptaps;
    rsc_state_t d_pad;
    rsc_step_t  r;
    logic       step_unused;

    // Reverse the MSB-first polynomials into per-delay tap masks.
    for (genvar k = 0; k < MAX_M; k++) begin : g_rtap
        if (k < M) begin : g_on
            assign rtaps[k] = 1'(RECURSIVE >> (M - 1 - k));
        end else begin : g_off
            assign rtaps[k] = 1'b0;
        end
    end

    for (genvar j = 0; j < MAX_NOUT; j++) begin : g_pj
        for (genvar k = 0; k <= MAX_M; k++) begin : g_pk
            if (j < NOUT && k <= M) begin : g_on
                assign ptaps[j][k] = 1'(POLY[j] >> (M - k));
            end else begin : g_off
                assign ptaps[j][k] = 1'b0;
            end
        end
    end

    assign d_pad = rsc_state_t'(state);

    always_comb begin
        u_eff = tail ? rsc_feedback(d_pad, rtaps) : u;
        r     = rsc_step(d_pad, u_eff, rtaps, ptaps);
    end

    assign state_nx    = r.next[M-1:0];
    assign symbol      = r.sym[NOUT-1:0];
    assign step_unused = ^r;

endmodule

// File: rtl/rsc_encoder.sv
// RSC constituent encoder with valid/ready handshake on both sides.
// Tail termination to state 0 is built when RSC_TAIL_TERMINATION_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// DATA    | accept data bits, one trellis step per accepted bit
// TAIL    | M internal steps with u = feedback taps, drives d to 0
module rsc_encoder
    import turbo_pkg::*;
#(
    parameter int STATES    = 4,
    parameter int NIN       = 1,
    parameter int NOUT      = 2,
    parameter int RECURSIVE = 7,
    parameter int POLY [NOUT] = '{5, 7},
    parameter int SYMBOLS   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NIN-1:0]  in_bit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NOUT-1:0] out_symbol,
    output logic [NIN-1:0]  out_sys,
    output logic            out_tail,
    output logic            out_last
);

    localparam int M  = mem_len(STATES);
    localparam int CW = $clog2(SYMBOLS + M + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(SYMBOLS - 1);
`ifdef RSC_TAIL_TERMINATION_EN
    localparam logic [CW-1:0] LAST_TAIL = CW'(SYMBOLS + M - 1);
`endif

    if (NIN != 1) begin : g_nin_check
        $error("rsc_encoder: only NIN = 1 is supported");
    end

    enc_fsm_e        state_q, state_nx;
    logic [M-1:0]    d_q;
    logic [CW-1:0]   count_q;
    logic            step_en;
    logic            last_step;
    logic            tail_step;
    logic [M-1:0]    d_step;
    logic [NOUT-1:0] sym_step;
    logic            u_step;

    rsc_step_logic #(
        .STATES    (STATES),
        .NOUT      (NOUT),
        .RECURSIVE (RECURSIVE),
        .POLY      (POLY)
    ) u_step_logic (
        .state    (d_q),
        .tail     (tail_step),
        .u        (in_bit[0]),
        .state_nx (d_step),
        .symbol   (sym_step),
        .u_eff    (u_step)
    );

    always_comb begin
        state_nx  = state_q;
        in_ready  = 1'b0;
        step_en   = 1'b0;
        last_step = 1'b0;
        tail_step = 1'b0;
        case (state_q)
            ST_DATA: begin
                in_ready = !out_valid || out_ready;
                step_en  = in_valid && in_ready;
                if (step_en && count_q == LAST_DATA) begin
`ifdef RSC_TAIL_TERMINATION_EN
                    state_nx = ST_TAIL;
`else
                    last_step = 1'b1;
`endif
                end
            end
            ST_TAIL: begin
`ifdef RSC_TAIL_TERMINATION_EN
                tail_step = 1'b1;
                step_en   = !out_valid || out_ready;
                if (step_en && count_q == LAST_TAIL) begin
                    last_step = 1'b1;
                    state_nx  = ST_DATA;
                end
`else
                state_nx = ST_DATA;
`endif
            end
            default: state_nx = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_DATA;
            d_q        <= '0;
            count_q    <= '0;
            out_valid  <= 1'b0;
            out_symbol <= '0;
            out_sys    <= '0;
            out_tail   <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            state_q <= state_nx;
            if (step_en) begin
                // Terminated frames already land in 0; unterminated ones are cleared here.
                d_q        <= last_step ? '0 : d_step;
                count_q    <= last_step ? '0 : count_q + 1'b1;
                out_valid  <= 1'b1;
                out_symbol <= sym_step;
                out_sys    <= NIN'(u_step);
                out_tail   <= tail_step;
                out_last   <= last_step;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rsc_encoder.sv
// Self-checking bench for rsc_encoder: fixed vectors, back-to-back, stall, reset and random frames.
module tb_rsc_encoder;

    localparam int M         = 2;
    localparam int SYMBOLS   = 4;
    localparam int RECURSIVE = 7;
    localparam int POLY0     = 5;
    localparam int POLY1     = 7;
`ifdef RSC_TAIL_TERMINATION_EN
    localparam bit TAIL_EN   = 1'b1;
    localparam int EXP_STALL = M;
`else
    localparam bit TAIL_EN   = 1'b0;
    localparam int EXP_STALL = 0;
`endif

    typedef struct packed {
        logic [1:0] sym;
        logic       sys;
        logic       tail;
        logic       last;
    } obs_t;

    typedef struct {
        logic       u;
        logic [1:0] sym;
        logic       sys;
        logic       tail;
        logic       last;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [0:0] in_bit = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_symbol;
    logic [0:0] out_sys;
    logic       out_tail;
    logic       out_last;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rmode = 0;
    obs_t obs_q[$];
    obs_t exp_q[$];
    vec_t tbl[$];

    rsc_encoder #(
        .STATES(4), .NIN(1), .NOUT(2), .RECURSIVE(RECURSIVE), .SYMBOLS(SYMBOLS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_symbol(out_symbol), .out_sys(out_sys),
        .out_tail(out_tail), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: polynomial taps applied to the delay line as integer parity.
    function automatic int rev_taps(input int p);
        int r = 0;
        for (int b = 0; b <= M; b++)
            if (((p >> (M - b)) & 1) != 0) r |= (1 << b);
        return r;
    endfunction

    function automatic obs_t model_step(inout int s, input logic u, input bit tail, input bit last);
        obs_t o;
        int   w;
        logic a;
        a      = u ^ (^((s << 1) & rev_taps(RECURSIVE)));
        w      = (s << 1) | int'(a);
        o.sym  = {^(w & rev_taps(POLY1)), ^(w & rev_taps(POLY0))};
        o.sys  = u;
        o.tail = tail;
        o.last = last;
        s      = w & ((1 << M) - 1);
        return o;
    endfunction

    task automatic model_frame(input logic [SYMBOLS-1:0] bits);
        int   s = 0;
        logic u;
        for (int i = 0; i < SYMBOLS; i++)
            exp_q.push_back(model_step(s, bits[i], 1'b0, !TAIL_EN && i == SYMBOLS - 1));
        if (TAIL_EN) begin
            for (int t = 0; t < M; t++) begin
                u = ^((s << 1) & rev_taps(RECURSIVE));
                exp_q.push_back(model_step(s, u, 1'b1, t == M - 1));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: records handshakes, checks that stalled outputs hold.
    initial begin
        logic       prev_stall = 1'b0;
        logic [4:0] held = '0;
        logic [4:0] cur;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                cur = {out_symbol, out_sys, out_tail, out_last};
                if (prev_stall) begin
                    chk("stall_valid", int'(out_valid), 1);
                    chk("stall_hold", int'(cur), int'(held));
                end
                if (out_valid && out_ready) obs_q.push_back(obs_t'(cur));
                prev_stall = out_valid && !out_ready;
                held       = cur;
            end
        end
    end

    task automatic send_bits(input logic [63:0] bits, input int n, output int stalls);
        int   idx = 0;
        int   guard = 0;
        logic acc;
        stalls = 0;
        while (idx < n && guard < 2000) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = bits[idx[5:0]];
            #1;
            acc = in_ready;
            if (!acc) stalls++;
            @(posedge clk);
            if (acc) idx++;
            guard++;
        end
        if (idx < n) chk("send_timeout", idx, n);
    endtask

    task automatic drain_and_compare(input string tag);
        int done = 0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 300 && done == 0; c++) begin
            @(negedge clk);
            #3;
            if (obs_q.size() >= exp_q.size() && !out_valid) done = 1;
        end
        if (done == 0) chk({tag, "_drain_timeout"}, obs_q.size(), exp_q.size());
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_sym[%0d]", tag, i),  int'(obs_q[i].sym),  int'(exp_q[i].sym));
            chk($sformatf("%s_sys[%0d]", tag, i),  int'(obs_q[i].sys),  int'(exp_q[i].sys));
            chk($sformatf("%s_tail[%0d]", tag, i), int'(obs_q[i].tail), int'(exp_q[i].tail));
            chk($sformatf("%s_last[%0d]", tag, i), int'(obs_q[i].last), int'(exp_q[i].last));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_table(input string tag);
        logic [63:0] bits = '0;
        int          n = 0;
        int          stalls;
        foreach (tbl[i]) begin
            if (!tbl[i].tail) begin
                bits[n[5:0]] = tbl[i].u;
                n++;
            end
            exp_q.push_back('{sym: tbl[i].sym, sys: tbl[i].sys, tail: tbl[i].tail, last: tbl[i].last});
        end
        send_bits(bits, n, stalls);
        drain_and_compare(tag);
        chk({tag, "_final_state"}, int'(dut.d_q), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stalls;
        logic [63:0] bits;

        tbl.push_back('{u: 1'b1, sym: 2'b11, sys: 1'b1, tail: 1'b0, last: 1'b0});
        tbl.push_back('{u: 1'b0, sym: 2'b01, sys: 1'b0, tail: 1'b0, last: 1'b0});
        tbl.push_back('{u: 1'b0, sym: 2'b01, sys: 1'b0, tail: 1'b0, last: 1'b0});
        tbl.push_back('{u: 1'b0, sym: 2'b00, sys: 1'b0, tail: 1'b0, last: !TAIL_EN});
`ifdef RSC_TAIL_TERMINATION_EN
        tbl.push_back('{u: 1'b0, sym: 2'b10, sys: 1'b1, tail: 1'b1, last: 1'b0});
        tbl.push_back('{u: 1'b0, sym: 2'b11, sys: 1'b1, tail: 1'b1, last: 1'b1});
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_symbol", int'(out_symbol), 0);
        chk("rst_out_sys", int'(out_sys), 0);
        chk("rst_out_tail", int'(out_tail), 0);
        chk("rst_out_last", int'(out_last), 0);
        @(negedge clk);
        reset_n = 1'b1;

        rmode = 0;
        run_table("vec");
        run_table("vec_again");

        // Two frames with in_valid held high across the frame boundary.
        bits = '0;
        bits[7:0] = 8'b0110_1011;
        model_frame(bits[3:0]);
        model_frame(bits[7:4]);
        send_bits(bits, 2 * SYMBOLS, stalls);
        chk("b2b_stall_cycles", stalls, EXP_STALL);
        drain_and_compare("b2b");

        rmode = 1;
        run_table("toggle");

        rmode = 2;
        for (int f = 0; f < 12; f++) begin
            bits = 64'($urandom_range(0, (1 << SYMBOLS) - 1));
            model_frame(bits[SYMBOLS-1:0]);
            send_bits(bits, SYMBOLS, stalls);
        end
        drain_and_compare("rand");

        // Asynchronous reset two bits into a frame.
        rmode = 0;
        bits = 64'b01;
        send_bits(bits, 2, stalls);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_symbol", int'(out_symbol), 0);
        chk("mid_rst_out_sys", int'(out_sys), 0);
        chk("mid_rst_out_tail", int'(out_tail), 0);
        chk("mid_rst_out_last", int'(out_last), 0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        run_table("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
